regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 8 +
 rtl/regfile_wb_arbiter_if.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package regfile_pkg;
   typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} arb_state_e;

   localparam int         REG_AW           = 5;
   localparam logic [4:0] REG_ZERO         = 5'd0;
   localparam int         STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/response bus between the two requesters and the arbiter.
interface regfile_wb_arbiter_if
   import regfile_pkg::*;
#(
   parameter int N = 32
);
   logic              WbValid0;
   logic [REG_AW-1:0] WbReg0;
   logic [N-1:0]      WbData0;
   logic              WbReady0;
   logic              WbValid1;
   logic [REG_AW-1:0] WbReg1;
   logic [N-1:0]      WbData1;
   logic              WbReady1;
   logic              RegWrite;
   logic [REG_AW-1:0] WriteReg;
   logic [N-1:0]      WriteData;
   logic [15:0]       ConflictCount;

   modport slave (
      input  WbValid0, WbReg0, WbData0, WbValid1, WbReg1, WbData1,
      output WbReady0, WbReady1, RegWrite, WriteReg, WriteData, ConflictCount
   );

   modport master (
      output WbValid0, WbReg0, WbData0, WbValid1, WbReg1, WbData1,
      input  WbReady0, WbReady1, RegWrite, WriteReg, WriteData, ConflictCount
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file write-port arbiter; requester 0 preferred,
// requester 1 promoted after STARVE_LIMIT consecutive lost contention cycles.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int N            = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                Clock,
   input  logic                Reset,
   regfile_wb_arbiter_if.slave bus
);
   localparam logic [3:0] AGE_LAST = 4'(STARVE_LIMIT - 1);

   arb_state_e        state_q, state_d;
   logic [3:0]        age_q, age_d;
   logic              reg_write_q, reg_write_d;
   logic [REG_AW-1:0] write_reg_q, write_reg_d;
   logic [N-1:0]      write_data_q, write_data_d;
   logic [15:0]       conflict_q, conflict_d;

   logic z0, z1, req0, req1, contention;
   logic ready0, ready1, grant0, grant1;

   // x0 writes are acknowledged but never occupy the port
   assign z0         = (bus.WbReg0 == REG_ZERO);
   assign z1         = (bus.WbReg1 == REG_ZERO);
   assign req0       = bus.WbValid0 && !z0;
   assign req1       = bus.WbValid1 && !z1;
   assign contention = req0 && req1;

   // Output process: handshake and grants
   always_comb begin
      ready0 = !Reset && bus.WbValid0 && (z0 || !contention || state_q == PRI0);
      ready1 = !Reset && bus.WbValid1 && (z1 || !contention || state_q == PRI1);
      grant0 = req0 && ready0;
      grant1 = req1 && ready1;
   end

   assign bus.WbReady0 = ready0;
   assign bus.WbReady1 = ready1;

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= PRI0;
         age_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         age_q   <= age_d;
      end
   end

   // Next-state process
   always_comb begin
      state_d = state_q;
      age_d   = age_q;
      case (state_q)
         PRI0: begin
            if (contention) begin
               if (age_q == AGE_LAST) begin
                  state_d = PRI1;
                  age_d   = 4'd0;
               end else begin
                  age_d = age_q + 4'd1;
               end
            end else if (!bus.WbValid1 || grant1) begin
               age_d = 4'd0;
            end
         end
         PRI1: begin
            age_d = 4'd0;
            if (grant1) state_d = PRI0;
         end
         default: begin
            state_d = PRI0;
            age_d   = 4'd0;
         end
      endcase
   end

   // Write port: at most one nonzero grant per cycle
   always_comb begin
      reg_write_d  = grant0 || grant1;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      conflict_d   = conflict_q + {15'd0, contention};
      if (grant0) begin
         write_reg_d  = bus.WbReg0;
         write_data_d = bus.WbData0;
      end else if (grant1) begin
         write_reg_d  = bus.WbReg1;
         write_data_d = bus.WbData1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         reg_write_q  <= 1'b0;
         write_reg_q  <= REG_ZERO;
         write_data_q <= '0;
         conflict_q   <= 16'd0;
      end else begin
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         conflict_q   <= conflict_d;
      end
   end

   assign bus.RegWrite      = reg_write_q;
   assign bus.WriteReg      = write_reg_q;
   assign bus.WriteData     = write_data_q;
   assign bus.ConflictCount = conflict_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Vector table with expected handshakes; expected writes are queued and
// compared against the registered write port one cycle later.
module tb_regfile_wb_arbiter;
   typedef struct {
      bit          rst;
      bit          v0;
      logic [4:0]  r0;
      logic [31:0] d0;
      bit          v1;
      logic [4:0]  r1;
      logic [31:0] d1;
      bit          e0;
      bit          e1;
   } vec_t;

   typedef struct {
      bit          we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic [15:0] cc;
   } exp_t;

   logic Clock = 1'b0;
   logic Reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   vec_t vecs[$];
   exp_t sb[$];
   bit          m_we;
   logic [4:0]  m_reg;
   logic [31:0] m_data;
   logic [15:0] m_cc;

   regfile_wb_arbiter_if #(.N(32)) bus ();

   regfile_wb_arbiter #(.N(32), .STARVE_LIMIT(4)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rst, bit v0, logic [4:0] r0, logic [31:0] d0,
                               bit v1, logic [4:0] r1, logic [31:0] d1, bit e0, bit e1);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.r0 = r0; v.d0 = d0;
      v.v1 = v1; v.r1 = r1; v.d1 = d1; v.e0 = e0; v.e1 = e1;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      Reset        = v.rst;
      bus.WbValid0 = v.v0; bus.WbReg0 = v.r0; bus.WbData0 = v.d0;
      bus.WbValid1 = v.v1; bus.WbReg1 = v.r1; bus.WbData1 = v.d1;
   endtask

   initial begin
      vec_t idle, both, only0;
      exp_t e;
      idle  = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
      both  = mk(0, 1, 5'd3, 32'h300, 1, 5'd7, 32'h700, 1, 0);
      only0 = mk(0, 1, 5'd3, 32'h300, 0, 5'd0, 32'h0, 1, 0);

      // reset with a pending request: no handshake
      vecs.push_back(mk(1, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66, 0, 0));
      vecs.push_back(mk(0, 1, 5'd5, 32'hAAAA5555, 0, 5'd0, 32'h0, 1, 0));
      vecs.push_back(idle);
      // starvation promotion after four lost contention cycles
      for (int i = 0; i < 4; i++) vecs.push_back(both);
      vecs.push_back(mk(0, 1, 5'd3, 32'h300, 1, 5'd7, 32'h700, 0, 1));
      vecs.push_back(both);
      vecs.push_back(idle);
      // x0 request alongside a nonzero one
      vecs.push_back(mk(0, 1, 5'd0, 32'hDEAD, 1, 5'd9, 32'h1234, 1, 1));
      vecs.push_back(idle);
      // same destination: winner then loser
      vecs.push_back(mk(0, 1, 5'd12, 32'h11, 1, 5'd12, 32'h22, 1, 0));
      vecs.push_back(mk(0, 0, 5'd0, 32'h0, 1, 5'd12, 32'h22, 0, 1));
      vecs.push_back(idle);
      // requester 1 dropping valid clears the age; PRI1 holds until it transfers
      vecs.push_back(both);
      vecs.push_back(both);
      vecs.push_back(only0);
      for (int i = 0; i < 4; i++) vecs.push_back(both);
      vecs.push_back(only0);
      vecs.push_back(mk(0, 1, 5'd3, 32'h300, 1, 5'd7, 32'h700, 0, 1));
      vecs.push_back(idle);
      // accepted write discarded by reset on the following edge
      vecs.push_back(mk(0, 1, 5'd4, 32'h44, 0, 5'd0, 32'h0, 1, 0));
      vecs.push_back(mk(1, 1, 5'd4, 32'h44, 1, 5'd8, 32'h88, 0, 0));
      vecs.push_back(both);
      vecs.push_back(idle);

      m_we = 0; m_reg = 5'd0; m_data = 32'h0; m_cc = 16'd0;
      foreach (vecs[i]) begin
         vec_t v;
         bit   t0, t1, c;
         v = vecs[i];
         drive(v);
         @(negedge Clock);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("v%0d RegWrite", i), 32'(bus.RegWrite), 32'(e.we));
            chk($sformatf("v%0d WriteReg", i), 32'(bus.WriteReg), 32'(e.wreg));
            chk($sformatf("v%0d WriteData", i), bus.WriteData, e.wdata);
            chk($sformatf("v%0d ConflictCount", i), 32'(bus.ConflictCount), 32'(e.cc));
         end
         chk($sformatf("v%0d WbReady0", i), 32'(bus.WbReady0), 32'(v.e0));
         chk($sformatf("v%0d WbReady1", i), 32'(bus.WbReady1), 32'(v.e1));
         t0 = v.e0 && v.v0 && (v.r0 != 5'd0);
         t1 = v.e1 && v.v1 && (v.r1 != 5'd0);
         c  = v.v0 && (v.r0 != 5'd0) && v.v1 && (v.r1 != 5'd0);
         if (v.rst) begin
            m_we = 0; m_reg = 5'd0; m_data = 32'h0; m_cc = 16'd0;
         end else begin
            m_we = t0 || t1;
            if (t0) begin m_reg = v.r0; m_data = v.d0; end
            else if (t1) begin m_reg = v.r1; m_data = v.d1; end
            m_cc = m_cc + (c ? 16'd1 : 16'd0);
         end
         e.we = m_we; e.wreg = m_reg; e.wdata = m_data; e.cc = m_cc;
         sb.push_back(e);
         @(posedge Clock);
         #1;
      end
      @(negedge Clock);
      e = sb.pop_front();
      chk("tail RegWrite", 32'(bus.RegWrite), 32'(e.we));
      chk("tail ConflictCount", 32'(bus.ConflictCount), 32'(e.cc));

      // conflict counter wraparound
      drive(mk(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0));
      @(posedge Clock);
      #1;
      drive(mk(0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0));
      repeat (65535) @(posedge Clock);
      #1;
      chk("cc saturate FFFF", 32'(bus.ConflictCount), 32'h0000FFFF);
      @(posedge Clock);
      #1;
      chk("cc wrap to 0", 32'(bus.ConflictCount), 32'h0);
      drive(idle);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
